// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: state encoding,
// bubble instruction and per-boundary field widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    localparam logic [15:0] PIPE_NOP_INSTR = 16'h0800;

    // Packed payload/control widths per stage boundary, shared by the wrappers
    localparam int FD_DATA_W = 32;
    localparam int FD_CTRL_W = 4;
    localparam int DE_DATA_W = 96;
    localparam int DE_CTRL_W = 16;
    localparam int EM_DATA_W = 64;
    localparam int EM_CTRL_W = 12;
    localparam int MW_DATA_W = 64;
    localparam int MW_CTRL_W = 8;

endpackage

// File: rtl/pipe_entry.sv
// One storage entry of a pipeline buffer: a load-enabled register that
// resets to the bubble word.
module pipe_entry #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] entry_q;
    logic [W-1:0] entry_d;

    always_comb begin
        entry_d = load ? d : entry_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) entry_q <= RST_VAL;
        else      entry_q <= entry_d;
    end

    assign q = entry_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline-stage buffer with a two-entry skid, flush, bubble
// masking and a saturating back-pressure counter.
//
//   state    | meaning
//   ST_EMPTY | nothing held, outputs show the bubble
//   ST_ONE   | head word in MAIN, still accepting
//   ST_TWO   | MAIN and SKID full, in_ready low
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter int                 CTRL_W    = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP_INSTR),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int                ENT_W   = INSTR_W + DATA_W + CTRL_W;
    localparam logic [ENT_W-1:0]  ENT_RST = {NOP_INSTR, {DATA_W{1'b0}}, {CTRL_W{1'b0}}};

    buf_state_t        state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              push, pop;
    logic              load_main, load_skid, main_from_skid;
    logic [ENT_W-1:0]  in_word, main_d, main_q, skid_q;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_word   = {in_instr, in_data, in_ctrl};

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    load_main = 1'b1;
                end else if (push) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d        = ST_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over everything; stale entry contents are hidden by the mask
        if (flush) begin
            state_d   = ST_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
        main_d = main_from_skid ? skid_q : in_word;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_entry #(.W(ENT_W), .RST_VAL(ENT_RST)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (load_main),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_entry #(.W(ENT_W), .RST_VAL(ENT_RST)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (load_skid),
        .d    (in_word),
        .q    (skid_q)
    );

    assign out_instr = out_valid ? main_q[ENT_W-1 -: INSTR_W] : NOP_INSTR;
    assign out_data  = out_valid ? main_q[CTRL_W +: DATA_W]   : '0;
    assign out_ctrl  = out_valid ? main_q[CTRL_W-1:0]         : '0;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage buffer that replaces the fixed-field, always-enabled inter-stage latches. It carries one instruction word, a DATA_W-bit datapath payload and a CTRL_W-bit control bundle between adjacent pipeline stages. It adds a valid/ready handshake with a two-entry skid buffer, synchronous flush, and bubble insertion (NOP instruction, zeroed control) whenever the output is invalid. It also adds a saturating back-pressure counter for performance debug. One instance sits on each stage boundary (F/D, D/E, E/M, M/W).

## Interface
Parameters:
- DATA_W, 64 — packed datapath payload width (PC, operands, immediate, …); ≥1
- CTRL_W, 16 — packed control bundle width (halt, link, memRead, branch, writeRegSel, …); ≥1
- INSTR_W, 16 — instruction word width
- NOP_INSTR, 16'h0800 — instruction presented while the output is invalid
- CNT_W, 16 — back-pressure counter width; ≥1

Ports:
- clk  in  1  — single clock; all state updates on the rising edge
- rst  in  1  — asynchronous, active-low reset
- in_valid  in  1  — upstream has a word to hand over
- in_ready  out  1  — buffer can accept; depends only on registered state
- in_instr  in  INSTR_W  — instruction word
- in_data  in  DATA_W  — datapath payload
- in_ctrl  in  CTRL_W  — control bundle
- flush  in  1  — synchronous kill of all held and incoming words
- out_valid  out  1  — head entry is valid
- out_ready  in  1  — downstream accepts the head this cycle
- out_instr  out  INSTR_W  — head instruction, or NOP_INSTR when !out_valid
- out_data  out  DATA_W  — head payload, or 0 when !out_valid
- out_ctrl  out  CTRL_W  — head control, or 0 when !out_valid
- occupancy  out  2  — number of held entries: 0, 1 or 2
- stall_cnt  out  CNT_W  — saturating count of cycles with out_valid & !out_ready

## Operation
- Storage: two entries, MAIN (the head) and SKID. Each entry holds {instr, data, ctrl}. State: EMPTY, ONE, TWO.
- Transfers: a push is in_valid & in_ready; a pop is out_valid & out_ready.
- in_ready = (state != TWO). out_valid = (state != EMPTY).
- Transitions when flush=0:
  - EMPTY: push → ONE, MAIN loaded.
  - ONE:
    - push & pop → ONE, MAIN reloaded.
    - push & !pop → TWO, SKID loaded.
    - pop & !push → EMPTY.
    - otherwise hold.
  - TWO: pop → ONE, MAIN ← SKID. No push is possible in TWO.
- Ordering is strict FIFO. No word is dropped or duplicated.
- flush=1 (highest priority):
  - Next state is EMPTY.
  - Any word pushed in the same cycle is discarded.
  - A pop in the same cycle still counts as consumed downstream.
  - Entry contents need not be cleared, because outputs are masked.
- Bubble masking is combinational from state: when !out_valid, out_instr=NOP_INSTR, out_data=0, out_ctrl=0.
- stall_cnt:
  - Increments on each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; flush does not clear it.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state=EMPTY, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
  - out_instr=NOP_INSTR, out_data=0, out_ctrl=0.
- Latency: push at edge N → out_valid=1 with that word after edge N, visible in cycle N+1.
- Throughput: one word per cycle with out_ready held high.
- Skid behaviour:
  - Downstream stall in cycle N deasserts in_ready only from cycle N+1.
  - The word pushed during cycle N lands in SKID.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Reset asserted mid-operation discards both entries. Outputs return to bubble values without waiting for a clock.
- flush and rst both produce bubbles. Only rst clears stall_cnt.

## Structure
- Shared package pipe_pkg holds:
  - the state typedef (EMPTY/ONE/TWO);
  - NOP_INSTR as the default-value constant;
  - per-boundary DATA_W/CTRL_W localparams, so the stage wrappers pack fields consistently.
- Sub-module pipe_entry: one storage entry of width INSTR_W+DATA_W+CTRL_W, with load enable and asynchronous active-low reset to {NOP_INSTR, 0, 0}. It is instantiated twice (MAIN, SKID).

## Test plan
- Reset, then stream 8 words (instr = 16'h1000+i) with out_ready=1 → outputs appear one cycle later in order, occupancy stays 1, stall_cnt=0.
- Push A, B, C with out_ready=0 from the cycle A appears → A and B held, occupancy=2, in_ready=0, C stalled. Raise out_ready → A, B, C emerge in order. stall_cnt equals the stalled-cycle count.
- In state TWO, assert flush with in_valid=1 → next cycle out_valid=0, out_instr=16'h0800, out_ctrl=0, occupancy=0. The pushed word never appears.
- Assert rst low mid-stream with occupancy=2 → outputs show bubble values before the next clk edge, in_ready=1. After release, the first pushed word is the first out.
- With CNT_W=3, hold out_valid=1, out_ready=0 for 12 cycles → stall_cnt saturates at 7. flush leaves it at 7.
- Random valid/ready/flush over 10k cycles against a queue scoreboard → no loss, duplication or reordering, and in_ready never depends on same-cycle out_ready.
